bram_arbiter: RTL and testbench
===============================

BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, BRAM word width.
REQ-002 Parameter ADDR_WIDTH, default 10, BRAM word-address width.
REQ-003 One clock; reset is asynchronous and active-low; ports are named i_clk and i_rst_n.
REQ-004 i_clk  in  1  system clock; all state updates on its rising edge.
REQ-005 i_rst_n  in  1  asynchronous active-low reset.
REQ-006 i_req_valid  in  2  per-requester access request; index 0 = requester A, index 1 = requester B.
REQ-007 i_req_we  in  2  per-requester write enable (1 = write, 0 = read).
REQ-008 i_req_addr  in  2 x ADDR_WIDTH  per-requester word address.
REQ-009 i_req_din  in  2 x DATA_WIDTH  per-requester write data.
REQ-010 o_req_ready  out  2  one-hot grant; the access is accepted in any cycle where valid and ready are both 1.
REQ-011 o_rsp_valid  out  2  one-hot read-data strobe for the owning requester.
REQ-012 o_rsp_data  out  DATA_WIDTH  read data, shared by both requesters, qualified by o_rsp_valid.
REQ-013 bram_port  bram_port_if.master  -  drives we, addr and din; samples dout.

Function
REQ-014 The block SHALL grant at most one requester per cycle; o_req_ready is combinational from i_req_valid and the priority pointer.
REQ-015 A single active requester SHALL be granted in the same cycle.
REQ-016 When both requesters are valid, the block SHALL grant the one not granted last (round-robin); the pointer SHALL update only on an accepted access.
REQ-017 On an accepted access, bram_port.we/addr/din SHALL equal the granted requester's i_req_we/i_req_addr/i_req_din in that same cycle.
REQ-018 With no accepted access, bram_port.we SHALL be 0 and bram_port.addr/din SHALL hold their last driven values.
REQ-019 BRAM read latency is 1 cycle; for an accepted read in cycle N, o_rsp_valid[owner] SHALL be 1 in cycle N+1 with o_rsp_data = bram_port.dout.
REQ-020 Accepted writes SHALL produce no o_rsp_valid pulse.
REQ-021 Back-to-back accesses SHALL be accepted every cycle with no bubble, including alternating A/B reads; the response owner SHALL be tracked in a registered owner/pending pair.
REQ-022 A requester SHALL hold valid, we, addr and din stable until ready; dropping valid before ready SHALL be legal and SHALL NOT corrupt the pointer.
REQ-023 The block SHALL keep two 32-bit saturating grant counters (A, B), readable hierarchically for debug; they SHALL hold at 0xFFFF_FFFF.

Reset
REQ-024 While i_rst_n = 0: o_req_ready = 0, o_rsp_valid = 0, o_rsp_data = 0, bram_port.we = 0, bram_port.addr = 0, bram_port.din = 0, pointer = A preferred, pending = 0, counters = 0.
REQ-025 A reset asserted in the cycle after a read SHALL suppress that read's o_rsp_valid.
REQ-026 The first grant after reset release SHALL go to A if both requesters are valid.

Structure
REQ-027 The shared package bram_arb_pkg SHALL hold localparam NUM_REQ = 2 and the owner_t enum {OWN_A, OWN_B}.
REQ-028 Round-robin selection SHALL live in one sub-module rr_arbiter2 (inputs: req[1:0], advance; output: gnt[1:0]).
REQ-029 The BRAM SHALL sit outside this block; only the bram_port_if master modport is used.

Verification
REQ-030 Reset, then A reads addr 5 (BRAM[5] = 0xDEAD_BEEF) -> ready[0] in cycle 0; rsp_valid = 01 and data 0xDEAD_BEEF in cycle 1.
REQ-031 A and B both valid continuously, reads to 1/2 -> grants alternate A, B, A, B; responses follow one cycle later with matching owner and data.
REQ-032 B writes 0x1234 to addr 7, then A reads addr 7 next cycle -> A receives 0x1234; no rsp pulse for B.
REQ-033 Idle for 10 cycles -> bram_port.we = 0 throughout; no rsp_valid pulses.
REQ-034 Reset asserted the cycle after an accepted read -> rsp_valid stays 0; all outputs at reset values.
REQ-035 Counter preloaded to 0xFFFF_FFFE, then 3 grants to A -> counter reads 0xFFFF_FFFF.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared definitions for the two-requester BRAM arbiter.
//   NUM_REQ   : number of requesters sharing the BRAM port (A = 0, B = 1)
//   CNT_WIDTH : width of the per-requester grant counters
//   owner_t   : identifies which requester owns a grant or a pending response
//   sat_inc   : saturating increment used by the grant counters
package bram_arb_pkg;

    localparam int NUM_REQ   = 2;
    localparam int CNT_WIDTH = 32;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/bram_port_if.sv
// Single-port synchronous BRAM connection.
//   we   : write enable, one-cycle strobe
//   addr : word address
//   din  : write data
//   dout : read data, valid the cycle after the address was presented
// master modport = the arbiter side, slave modport = the memory side.
interface bram_port_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;

    modport master (output we, output addr, output din, input dout);
    modport slave  (input we, input addr, input din, output dout);
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   req[1:0]       : request lines (0 = A, 1 = B)
//   advance        : the current grant was accepted; move the pointer
//   gnt[1:0]       : one-hot grant, combinational from req and the pointer
// The pointer names the requester preferred on a tie; it resets to A and only
// moves when advance is high, so a request withdrawn before acceptance has
// no effect on fairness.
module rr_arbiter2
    import bram_arb_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] gnt
);

    owner_t ptr_q;

    always_comb begin
        gnt = '0;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (ptr_q == OWN_A) ? 2'b01 : 2'b10;
            default: gnt = '0;
        endcase
    end

    // After serving a requester, prefer the other one on the next tie.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q <= OWN_A;
        end else if (advance) begin
            ptr_q <= gnt[0] ? OWN_B : OWN_A;
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// Arbitrates two requesters onto one single-port BRAM (BRAM lives outside).
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_req_valid/we/addr/din [2] : per-requester request (0 = A, 1 = B)
//   o_req_ready [2]: one-hot grant
//   o_rsp_valid [2]: one-hot read-data strobe for the owning requester
//   o_rsp_data     : shared read data, qualified by o_rsp_valid
//   bram_port      : master side of the BRAM port
// Handshake: a request is accepted in any cycle where i_req_valid[i] and
// o_req_ready[i] are both 1; the requester keeps we/addr/din stable while
// valid and not ready, and may withdraw valid before it is accepted. A read
// accepted in cycle N returns o_rsp_valid[i] with data in cycle N+1; writes
// return nothing. An access may be accepted every cycle.
// cnt_a / cnt_b are saturating grant counters kept for hierarchical debug.
module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic [NUM_REQ-1:0]                   i_req_valid,
    input  logic [NUM_REQ-1:0]                   i_req_we,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   i_req_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   i_req_din,
    output logic [NUM_REQ-1:0]                   o_req_ready,
    output logic [NUM_REQ-1:0]                   o_rsp_valid,
    output logic [DATA_WIDTH-1:0]                o_rsp_data,
    bram_port_if.master                          bram_port
);

    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    grant;
    logic                  accept;
    logic                  sel_idx;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic                  pend_q;
    owner_t                own_q;
    logic [CNT_WIDTH-1:0]  cnt_a;
    logic [CNT_WIDTH-1:0]  cnt_b;

    rr_arbiter2 u_rr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .req     (i_req_valid),
        .advance (accept),
        .gnt     (gnt)
    );

    // Grants are masked while reset is held so nothing is offered to the
    // requesters or the BRAM during reset.
    assign grant       = gnt & {NUM_REQ{i_rst_n}};
    assign accept      = |grant;
    assign sel_idx     = grant[1];
    assign sel_we      = i_req_we[sel_idx];
    assign o_req_ready = grant;

    // Address and data pass straight through on an accepted access and
    // otherwise hold the last value driven, keeping the BRAM pins quiet.
    assign bram_port.we   = accept & sel_we;
    assign bram_port.addr = accept ? i_req_addr[sel_idx] : addr_q;
    assign bram_port.din  = accept ? i_req_din[sel_idx]  : din_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q <= '0;
            din_q  <= '0;
        end else if (accept) begin
            addr_q <= i_req_addr[sel_idx];
            din_q  <= i_req_din[sel_idx];
        end
    end

    // One read can be in flight at a time (BRAM latency is one cycle), so a
    // single pending flag plus owner is enough to route every response.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend_q <= 1'b0;
            own_q  <= OWN_A;
        end else begin
            pend_q <= accept & ~sel_we;
            own_q  <= sel_idx ? OWN_B : OWN_A;
        end
    end

    assign o_rsp_valid = pend_q ? ((own_q == OWN_B) ? 2'b10 : 2'b01) : 2'b00;
    assign o_rsp_data  = pend_q ? bram_port.dout : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (grant[0]) cnt_a <= sat_inc(cnt_a);
            if (grant[1]) cnt_b <= sat_inc(cnt_b);
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed testbench for bram_arbiter with a behavioural one-cycle BRAM.
module tb_bram_arbiter;

    logic             i_clk;
    logic             i_rst_n;
    logic [1:0]       i_req_valid;
    logic [1:0]       i_req_we;
    logic [1:0][9:0]  i_req_addr;
    logic [1:0][31:0] i_req_din;
    logic [1:0]       o_req_ready;
    logic [1:0]       o_rsp_valid;
    logic [31:0]      o_rsp_data;

    int n_checks = 0;
    int n_fail   = 0;

    bram_port_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bram ();

    bram_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req_valid (i_req_valid),
        .i_req_we    (i_req_we),
        .i_req_addr  (i_req_addr),
        .i_req_din   (i_req_din),
        .o_req_ready (o_req_ready),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_data  (o_rsp_data),
        .bram_port   (bram)
    );

    // clock / reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // behavioural read-first BRAM, one cycle of read latency
    logic [31:0] mem [1024];
    always @(posedge i_clk) begin
        if (bram.we) mem[bram.addr] <= bram.din;
        bram.dout <= mem[bram.addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock cycle: drive on the falling edge, check 1 ns later.
    // Grant/BRAM-port values belong to this cycle; rsp values come from the
    // access accepted in the previous cycle.
    task automatic run_cycle(input string tag,
                             input logic [1:0] v, input logic [1:0] we,
                             input logic [9:0] a_addr, input logic [9:0] b_addr,
                             input logic [31:0] b_din,
                             input logic [1:0] x_rdy, input logic x_we,
                             input logic [9:0] x_addr, input logic [31:0] x_din,
                             input logic [1:0] x_rv, input logic [31:0] x_rd);
        @(negedge i_clk);
        i_req_valid   = v;
        i_req_we      = we;
        i_req_addr[0] = a_addr;
        i_req_addr[1] = b_addr;
        i_req_din[0]  = 32'h0;
        i_req_din[1]  = b_din;
        #1;
        check_eq({tag, ".ready"},    {30'h0, o_req_ready}, {30'h0, x_rdy});
        check_eq({tag, ".we"},       {31'h0, bram.we},     {31'h0, x_we});
        check_eq({tag, ".addr"},     {22'h0, bram.addr},   {22'h0, x_addr});
        check_eq({tag, ".din"},      bram.din,             x_din);
        check_eq({tag, ".rsp_v"},    {30'h0, o_rsp_valid}, {30'h0, x_rv});
        check_eq({tag, ".rsp_d"},    o_rsp_data,           x_rd);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".ready"}, {30'h0, o_req_ready}, 32'h0);
        check_eq({tag, ".we"},    {31'h0, bram.we},     32'h0);
        check_eq({tag, ".addr"},  {22'h0, bram.addr},   32'h0);
        check_eq({tag, ".din"},   bram.din,             32'h0);
        check_eq({tag, ".rsp_v"}, {30'h0, o_rsp_valid}, 32'h0);
        check_eq({tag, ".rsp_d"}, o_rsp_data,           32'h0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[1] = 32'h1111_0001;
        mem[2] = 32'h2222_0002;
        mem[5] = 32'hDEAD_BEEF;

        // reset with both requesters asserting: nothing may be granted
        i_rst_n     = 1'b0;
        i_req_valid = 2'b11;
        i_req_we    = 2'b11;
        i_req_addr  = '0;
        i_req_din   = '1;
        repeat (2) @(negedge i_clk);
        #1;
        check_reset_outputs("rst");
        check_eq("rst.cnt_a", dut.cnt_a, 32'h0);
        check_eq("rst.cnt_b", dut.cnt_b, 32'h0);
        i_req_valid = 2'b00;
        i_req_we    = 2'b00;
        i_req_din   = '0;
        i_rst_n     = 1'b1;

        // first tie after reset goes to A; response next cycle
        //         tag    v      we     aA     aB     dB            rdy    we    addr   din           rv     rd
        run_cycle("c1",  2'b11, 2'b00, 10'd5, 10'd2, 32'h0,        2'b01, 1'b0, 10'd5, 32'h0,        2'b00, 32'h0);
        // A alone is granted immediately even though the pointer prefers B
        run_cycle("c2",  2'b01, 2'b00, 10'd5, 10'd2, 32'h0,        2'b01, 1'b0, 10'd5, 32'h0,        2'b01, 32'hDEAD_BEEF);
        run_cycle("c3",  2'b00, 2'b00, 10'd5, 10'd2, 32'h0,        2'b00, 1'b0, 10'd5, 32'h0,        2'b01, 32'hDEAD_BEEF);
        run_cycle("c4",  2'b00, 2'b00, 10'd5, 10'd2, 32'h0,        2'b00, 1'b0, 10'd5, 32'h0,        2'b00, 32'h0);

        // both valid continuously: grants alternate, no bubbles
        run_cycle("c5",  2'b11, 2'b00, 10'd1, 10'd2, 32'h0,        2'b10, 1'b0, 10'd2, 32'h0,        2'b00, 32'h0);
        run_cycle("c6",  2'b11, 2'b00, 10'd1, 10'd2, 32'h0,        2'b01, 1'b0, 10'd1, 32'h0,        2'b10, 32'h2222_0002);
        run_cycle("c7",  2'b11, 2'b00, 10'd1, 10'd2, 32'h0,        2'b10, 1'b0, 10'd2, 32'h0,        2'b01, 32'h1111_0001);
        run_cycle("c8",  2'b11, 2'b00, 10'd1, 10'd2, 32'h0,        2'b01, 1'b0, 10'd1, 32'h0,        2'b10, 32'h2222_0002);
        run_cycle("c9",  2'b00, 2'b00, 10'd1, 10'd2, 32'h0,        2'b00, 1'b0, 10'd1, 32'h0,        2'b01, 32'h1111_0001);

        // B writes addr 7, A reads it back; the write gives no response
        run_cycle("c10", 2'b10, 2'b10, 10'd0, 10'd7, 32'h0000_1234, 2'b10, 1'b1, 10'd7, 32'h0000_1234, 2'b00, 32'h0);
        run_cycle("c11", 2'b01, 2'b00, 10'd7, 10'd0, 32'h0,        2'b01, 1'b0, 10'd7, 32'h0,        2'b00, 32'h0);
        run_cycle("c12", 2'b00, 2'b00, 10'd7, 10'd0, 32'h0,        2'b00, 1'b0, 10'd7, 32'h0,        2'b01, 32'h0000_1234);

        // A loses a tie and withdraws; the pointer must still favour A next
        run_cycle("c13", 2'b11, 2'b00, 10'd1, 10'd2, 32'h0,        2'b10, 1'b0, 10'd2, 32'h0,        2'b00, 32'h0);
        run_cycle("c14", 2'b10, 2'b00, 10'd1, 10'd2, 32'h0,        2'b10, 1'b0, 10'd2, 32'h0,        2'b10, 32'h2222_0002);
        run_cycle("c15", 2'b11, 2'b00, 10'd1, 10'd2, 32'h0,        2'b01, 1'b0, 10'd1, 32'h0,        2'b10, 32'h2222_0002);
        run_cycle("c16", 2'b00, 2'b00, 10'd1, 10'd2, 32'h0,        2'b00, 1'b0, 10'd1, 32'h0,        2'b01, 32'h1111_0001);

        // idle: port quiet, address held, no responses
        for (int i = 0; i < 10; i++) begin
            run_cycle("idle", 2'b00, 2'b00, 10'd9, 10'd9, 32'h0,   2'b00, 1'b0, 10'd1, 32'h0,        2'b00, 32'h0);
        end

        // reset in the cycle after an accepted read swallows the response
        run_cycle("c27", 2'b01, 2'b00, 10'd5, 10'd0, 32'h0,        2'b01, 1'b0, 10'd5, 32'h0,        2'b00, 32'h0);
        @(negedge i_clk);
        i_rst_n     = 1'b0;
        i_req_valid = 2'b11;
        #1;
        check_reset_outputs("mid_rst");
        check_eq("mid_rst.cnt_a", dut.cnt_a, 32'h0);
        @(negedge i_clk);
        i_req_valid = 2'b00;
        i_rst_n     = 1'b1;

        // saturating counter: preload, then three grants to A
        force dut.cnt_a = 32'hFFFF_FFFE;
        #1;
        release dut.cnt_a;
        check_eq("preload.cnt_a", dut.cnt_a, 32'hFFFF_FFFE);
        run_cycle("s1",  2'b11, 2'b00, 10'd5, 10'd2, 32'h0,        2'b01, 1'b0, 10'd5, 32'h0,        2'b00, 32'h0);
        run_cycle("s2",  2'b01, 2'b00, 10'd5, 10'd2, 32'h0,        2'b01, 1'b0, 10'd5, 32'h0,        2'b01, 32'hDEAD_BEEF);
        check_eq("s2.cnt_a", dut.cnt_a, 32'hFFFF_FFFF);
        run_cycle("s3",  2'b01, 2'b00, 10'd5, 10'd2, 32'h0,        2'b01, 1'b0, 10'd5, 32'h0,        2'b01, 32'hDEAD_BEEF);
        run_cycle("s4",  2'b00, 2'b00, 10'd5, 10'd2, 32'h0,        2'b00, 1'b0, 10'd5, 32'h0,        2'b01, 32'hDEAD_BEEF);
        check_eq("sat.cnt_a", dut.cnt_a, 32'hFFFF_FFFF);
        check_eq("sat.cnt_b", dut.cnt_b, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
